// File: rtl/usart_tx_serializer.sv
// Pulls bytes from the TX FIFO read port and serializes them as async frames:
// start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
module usart_tx_serializer #(
  parameter int unsigned CLOCKS_PER_BIT = 104,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic       comm_clock,
  input  logic       reset,
  output logic       fifo_ready,
  input  logic       fifo_valid,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       tx,
  output logic       busy,
  output logic       sent
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          par_bit, par_n;
  logic          stop_idx, stop_n;
  logic          tx_n, ready_n, busy_n, sent_n;
  logic          bit_end;

  always_ff @(posedge comm_clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      par_bit    <= 1'b0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      fifo_ready <= 1'b0;
      busy       <= 1'b0;
      sent       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      bit_idx    <= bit_idx_n;
      par_bit    <= par_n;
      stop_idx   <= stop_n;
      tx         <= tx_n;
      fifo_ready <= ready_n;
      busy       <= busy_n;
      sent       <= sent_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    par_n     = par_bit;
    stop_n    = stop_idx;
    tx_n      = tx;
    ready_n   = fifo_ready;
    busy_n    = busy;
    sent_n    = 1'b0;
    bit_end   = (cnt == '0);

    if ((state inside {S_START, S_DATA, S_PAR, S_STOP}) && !bit_end)
      cnt_n = cnt - 1'b1;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_n = S_FETCH;
          ready_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      S_FETCH: begin
        if (fifo_valid) begin
          shreg_n = fifo_data;
          par_n   = (PARITY == 2) ? ^fifo_data : ~^fifo_data;
          ready_n = 1'b0;
          tx_n    = 1'b0;
          cnt_n   = CNT_LOAD;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          tx_n      = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = '0;
          cnt_n     = CNT_LOAD;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n = CNT_LOAD;
          if (bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              state_n = S_PAR;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
              stop_n  = 1'b0;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
          stop_n  = 1'b0;
          cnt_n   = CNT_LOAD;
        end
      end
      S_STOP: begin
        // sent is registered, so it is armed one cycle ahead of the final stop cycle
        if (stop_idx == STOP_LAST && cnt == CNT_ONE)
          sent_n = 1'b1;
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            if (!fifo_empty) begin
              state_n = S_FETCH;
              ready_n = 1'b1;
            end else begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            stop_n = 1'b1;
            cnt_n  = CNT_LOAD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usart_tx_serializer.sv
// Bench for usart_tx_serializer: four parameter variants fed by a behavioural FIFO,
// outputs compared cycle by cycle against frames built from the byte stream.
module tb_usart_tx_serializer;

  localparam int unsigned CPB = 4;
  localparam int unsigned N   = 4;

  logic             comm_clock = 1'b0;
  logic             reset      = 1'b0;
  logic [N-1:0]     fifo_ready;
  logic [N-1:0]     fifo_valid = '0;
  logic [N-1:0]     fifo_empty;
  logic [N-1:0]     tx, busy, sent;
  logic [7:0]       fifo_data [N];
  logic [7:0]       fmem [N][64];
  int unsigned      wp [N] = '{0, 0, 0, 0};
  int unsigned      rp [N] = '{0, 0, 0, 0};
  logic [7:0]       pend [$];
  int               total = 0;
  int               bad   = 0;

  always #5 comm_clock = ~comm_clock;

  usart_tx_serializer #(.CLOCKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .comm_clock(comm_clock), .reset(reset), .fifo_ready(fifo_ready[0]), .fifo_valid(fifo_valid[0]),
    .fifo_data(fifo_data[0]), .fifo_empty(fifo_empty[0]), .tx(tx[0]), .busy(busy[0]), .sent(sent[0]));
  usart_tx_serializer #(.CLOCKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u1 (
    .comm_clock(comm_clock), .reset(reset), .fifo_ready(fifo_ready[1]), .fifo_valid(fifo_valid[1]),
    .fifo_data(fifo_data[1]), .fifo_empty(fifo_empty[1]), .tx(tx[1]), .busy(busy[1]), .sent(sent[1]));
  usart_tx_serializer #(.CLOCKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u2 (
    .comm_clock(comm_clock), .reset(reset), .fifo_ready(fifo_ready[2]), .fifo_valid(fifo_valid[2]),
    .fifo_data(fifo_data[2]), .fifo_empty(fifo_empty[2]), .tx(tx[2]), .busy(busy[2]), .sent(sent[2]));
  usart_tx_serializer #(.CLOCKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u3 (
    .comm_clock(comm_clock), .reset(reset), .fifo_ready(fifo_ready[3]), .fifo_valid(fifo_valid[3]),
    .fifo_data(fifo_data[3]), .fifo_empty(fifo_empty[3]), .tx(tx[3]), .busy(busy[3]), .sent(sent[3]));

  // FIFO read port: one-cycle valid pulse, a second pop is blocked while valid is high
  always @(posedge comm_clock) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_ready[i] && !fifo_valid[i] && wp[i] != rp[i]) begin
        fifo_valid[i] <= 1'b1;
        fifo_data[i]  <= fmem[i][rp[i] % 64];
        rp[i]         <= rp[i] + 1;
      end else begin
        fifo_valid[i] <= 1'b0;
        fifo_data[i]  <= 8'h00;
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < N; i++) fifo_empty[i] = (wp[i] == rp[i]);
  end

  function automatic int unsigned par_of(input int unsigned i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction

  function automatic int unsigned stops_of(input int unsigned i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pushes pend[] into one FIFO at once; expects per byte two fetch cycles then the frame.
  // Sample word is {tx, busy, fifo_ready, sent}.
  task automatic run(input int unsigned inst, input int unsigned limit);
    logic [3:0]  expq [$];
    logic        bits [$];
    logic [7:0]  b;
    int unsigned n;
    int unsigned rp0;
    @(negedge comm_clock);
    rp0 = rp[inst];
    foreach (pend[k]) begin
      b = pend[k];
      fmem[inst][wp[inst] % 64] = b;
      wp[inst]++;
      expq.push_back(4'b1110);
      expq.push_back(4'b1110);
      bits.delete();
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      if (par_of(inst) == 2) bits.push_back(($countones(b) % 2) == 1);
      else if (par_of(inst) == 1) bits.push_back(($countones(b) % 2) == 0);
      for (int j = 0; j < int'(stops_of(inst)); j++) bits.push_back(1'b1);
      for (int j = 0; j < bits.size(); j++)
        for (int c = 0; c < int'(CPB); c++)
          expq.push_back({bits[j], 1'b1, 1'b0, (j == bits.size() - 1 && c == int'(CPB) - 1)});
    end
    repeat (3) expq.push_back(4'b1000);
    n = 0;
    while (n < expq.size() && n < limit) begin
      @(posedge comm_clock);
      #1;
      for (int o = 0; o < int'(N); o++)
        chk($sformatf("u%0d_cyc%0d", o, n), {28'd0, tx[o], busy[o], fifo_ready[o], sent[o]},
            (o == int'(inst)) ? {28'd0, expq[n]} : 32'h8);
      n++;
    end
    if (n == expq.size())
      chk($sformatf("u%0d_pops", inst), rp[inst] - rp0, pend.size());
  endtask

  initial begin
    repeat (3) @(posedge comm_clock);
    #1;
    for (int o = 0; o < int'(N); o++)
      chk($sformatf("u%0d_reset", o), {28'd0, tx[o], busy[o], fifo_ready[o], sent[o]}, 32'h8);
    @(negedge comm_clock);
    reset = 1'b1;

    pend = '{8'h55};             run(0, 1000);
    pend = '{8'hA3, 8'h0F};      run(0, 1000);
    pend = '{8'h07};             run(1, 1000);
    pend = '{8'h07};             run(2, 1000);
    pend = '{8'hFF};             run(3, 1000);
    pend = '{8'h00, 8'hFF, 8'h80}; run(3, 1000);

    for (int r = 0; r < 5; r++) begin
      for (int unsigned i = 0; i < N; i++) begin
        pend.delete();
        repeat ($urandom_range(1, 3)) pend.push_back(8'($urandom));
        run(i, 1000);
      end
    end

    // abandon a frame two cycles into data bit 3
    pend = '{8'hC6};
    run(0, 20);
    @(negedge comm_clock);
    reset = 1'b0;
    @(posedge comm_clock);
    #1;
    for (int o = 0; o < int'(N); o++)
      chk($sformatf("u%0d_abort", o), {28'd0, tx[o], busy[o], fifo_ready[o], sent[o]}, 32'h8);
    chk("abort_popped", rp[0], wp[0]);
    @(negedge comm_clock);
    reset = 1'b1;
    pend = '{8'h3C, 8'h96};
    run(0, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
